// File: rtl/cpu_if.sv
// cpu_if - instruction-fetch stage and IF/ID pipeline register of the 16-bit CPU.
//
// The stage owns the PC and fetches one instruction per cycle over a
// req/valid handshake. A hit in the request cycle completes the fetch at once.
// A miss parks the stage in WAIT with the address held until the memory answers.
// The IF/ID register hands the instruction and its PC+2 to decode.
// Taken branches from decode redirect the PC and flush IF/ID. Hazard stalls
// freeze IF/ID and the PC. An HLT opcode stops fetching until a redirect or reset.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_stall        hazard-unit stall; hold PC and IF/ID
//   i_branchTake   decode resolved a taken branch this cycle
//   i_pcBranch     redirect target (bit 0 ignored)
//   o_imemReq      fetch request
//   o_imemAddr     fetch address (always the current PC)
//   i_imemData     instruction word, valid with i_imemValid
//   i_imemValid    request completes this cycle
//   o_instrOut     IF/ID instruction
//   o_pcPlus2Out   IF/ID PC+2 of o_instrOut
//   o_validOut     IF/ID holds a real instruction (0 = bubble)
//   o_fetchBusy    a memory request is outstanding
//   o_halted       fetch stopped on HLT
module cpu_if #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_branchTake,
    input  logic [15:0] i_pcBranch,
    output logic        o_imemReq,
    output logic [15:0] o_imemAddr,
    input  logic [15:0] i_imemData,
    input  logic        i_imemValid,
    output logic [15:0] o_instrOut,
    output logic [15:0] o_pcPlus2Out,
    output logic        o_validOut,
    output logic        o_fetchBusy,
    output logic        o_halted
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_redirectPc;
    logic [15:0] r_buffer;
    logic [15:0] r_instr;
    logic [15:0] r_pcPlus2;
    logic        r_valid;
    logic        r_squash;

    logic [15:0] w_pcPlus2;
    logic [15:0] w_target;
    logic [15:0] w_word;
    logic        w_isHalt;

    assign w_pcPlus2 = r_pc + 16'd2;
    assign w_target  = {i_pcBranch[15:1], 1'b0};

    // In HOLD the instruction retires from the buffer; otherwise it comes
    // straight from the memory data bus.
    assign w_word   = (r_state == ST_HOLD) ? r_buffer : i_imemData;
    assign w_isHalt = (w_word[15:12] == HALT_OPCODE);

    // A new request is only launched from FETCH when neither a stall nor a
    // redirect is pending. An outstanding request in WAIT is always kept up.
    assign o_imemReq    = (r_state == ST_WAIT) ||
                          ((r_state == ST_FETCH) && !i_stall && !i_branchTake);
    assign o_imemAddr   = r_pc;
    assign o_instrOut   = r_instr;
    assign o_pcPlus2Out = r_pcPlus2;
    assign o_validOut   = r_valid;
    assign o_fetchBusy  = (r_state == ST_WAIT);
    assign o_halted     = (r_state == ST_HALT);

    // Fetch FSM plus the PC and IF/ID register.
    // In WAIT a redirect cannot cancel the request already in flight. The
    // target is therefore remembered in r_redirectPc, and the late data is
    // discarded when it arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_redirectPc <= RESET_PC;
            r_buffer     <= 16'h0000;
            r_instr      <= NOP_INSTR;
            r_pcPlus2    <= 16'h0000;
            r_valid      <= 1'b0;
            r_squash     <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (i_branchTake) begin
                        r_pc      <= w_target;
                        r_instr   <= NOP_INSTR;
                        r_pcPlus2 <= 16'h0000;
                        r_valid   <= 1'b0;
                    end else if (!i_stall) begin
                        if (i_imemValid) begin
                            r_instr   <= w_word;
                            r_pcPlus2 <= w_pcPlus2;
                            r_valid   <= 1'b1;
                            r_pc      <= w_pcPlus2;
                            r_state   <= w_isHalt ? ST_HALT : ST_FETCH;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_branchTake) begin
                        r_redirectPc <= w_target;
                        r_squash     <= 1'b1;
                        r_instr      <= NOP_INSTR;
                        r_pcPlus2    <= 16'h0000;
                        r_valid      <= 1'b0;
                    end
                    if (i_imemValid) begin
                        if (r_squash || i_branchTake) begin
                            r_pc     <= i_branchTake ? w_target : r_redirectPc;
                            r_squash <= 1'b0;
                            r_state  <= ST_FETCH;
                        end else if (!i_stall) begin
                            r_instr   <= w_word;
                            r_pcPlus2 <= w_pcPlus2;
                            r_valid   <= 1'b1;
                            r_pc      <= w_pcPlus2;
                            r_state   <= w_isHalt ? ST_HALT : ST_FETCH;
                        end else begin
                            r_buffer <= i_imemData;
                            r_state  <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_branchTake) begin
                        r_pc      <= w_target;
                        r_instr   <= NOP_INSTR;
                        r_pcPlus2 <= 16'h0000;
                        r_valid   <= 1'b0;
                        r_state   <= ST_FETCH;
                    end else if (!i_stall) begin
                        r_instr   <= w_word;
                        r_pcPlus2 <= w_pcPlus2;
                        r_valid   <= 1'b1;
                        r_pc      <= w_pcPlus2;
                        r_state   <= w_isHalt ? ST_HALT : ST_FETCH;
                    end
                end
                ST_HALT: begin
                    // The HLT stays visible to decode for one unstalled cycle.
                    // After that, IF/ID shows a bubble.
                    if (i_branchTake) begin
                        r_pc      <= w_target;
                        r_instr   <= NOP_INSTR;
                        r_pcPlus2 <= 16'h0000;
                        r_valid   <= 1'b0;
                        r_state   <= ST_FETCH;
                    end else if (!i_stall) begin
                        r_instr   <= NOP_INSTR;
                        r_pcPlus2 <= 16'h0000;
                        r_valid   <= 1'b0;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule
